// File: rtl/ct_spsram_256x23_arb_ctrl.sv
// rtl/ct_spsram_256x23_arb_ctrl.sv - clear-on-init and round-robin read/write port controller for a 256x23 single-port SRAM
module ct_spsram_256x23_arb_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 23
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  init_req,
    output logic                  init_done,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_bwen,
    output logic                  wr_gnt,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic [DATA_WIDTH-1:0] sram_d,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    typedef enum logic [1:0] {
        INIT_WAIT = 2'd0,
        INIT      = 2'd1,
        IDLE      = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rr_wr_q, rr_wr_d;   // 1: write side wins the next contest
    logic                  init_done_q, init_done_d;
    logic                  rd_vld_q, rd_vld_d;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q     <= INIT_WAIT;
            cnt_q       <= '0;
            rr_wr_q     <= 1'b0;
            init_done_q <= 1'b0;
            rd_vld_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_wr_q     <= rr_wr_d;
            init_done_q <= init_done_d;
            rd_vld_q    <= rd_vld_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_wr_d     = rr_wr_q;
        init_done_d = init_done_q;
        rd_gnt      = 1'b0;
        wr_gnt      = 1'b0;
        sram_a      = '0;
        sram_cen    = 1'b1;
        sram_d      = '0;
        sram_gwen   = 1'b1;
        sram_wen    = '1;
        unique case (state_q)
            INIT_WAIT: begin
                state_d = INIT;
                cnt_d   = '0;
            end
            INIT: begin
                sram_a    = cnt_q;
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = '0;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end
            end
            IDLE: begin
                wr_gnt = wr_req & (~rd_req | rr_wr_q);
                rd_gnt = rd_req & ~wr_gnt;
                if (rd_req && wr_req) begin
                    rr_wr_d = ~rr_wr_q;
                end
                if (wr_gnt) begin
                    sram_a    = wr_addr;
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_wen  = wr_bwen;
                    sram_d    = wr_data;
                end else if (rd_gnt) begin
                    sram_a   = rd_addr;
                    sram_cen = 1'b0;
                end
                // The grant above still completes; the clear begins after a pass through INIT_WAIT.
                if (init_req) begin
                    state_d     = INIT_WAIT;
                    init_done_d = 1'b0;
                end
            end
            default: begin
                state_d = INIT_WAIT;
            end
        endcase
        rd_vld_d = rd_gnt;
    end

    assign init_done = init_done_q;
    assign rd_vld    = rd_vld_q;
    assign rd_data   = sram_q;

endmodule

// File: tb/tb_ct_spsram_256x23_arb_ctrl.sv
// tb/tb_ct_spsram_256x23_arb_ctrl.sv - self-checking bench with SRAM model and reference memory
module tb_ct_spsram_256x23_arb_ctrl;

    localparam int AW    = 8;
    localparam int DW    = 23;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          cpurst_b;
    logic          init_req;
    logic          init_done;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic          rd_vld;
    logic [DW-1:0] rd_data;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] wr_bwen;
    logic          wr_gnt;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic [DW-1:0] sram_d;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [DW-1:0] sram_q;

    logic [DW-1:0] sram_mem [DEPTH];
    logic          fill_garbage;

    logic [DW-1:0] ref_mem [DEPTH];
    bit            m_idle;
    bit            m_pref_wr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ct_spsram_256x23_arb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .forever_cpuclk(clk),
        .cpurst_b      (cpurst_b),
        .init_req      (init_req),
        .init_done     (init_done),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_gnt        (rd_gnt),
        .rd_vld        (rd_vld),
        .rd_data       (rd_data),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_bwen       (wr_bwen),
        .wr_gnt        (wr_gnt),
        .sram_a        (sram_a),
        .sram_cen      (sram_cen),
        .sram_d        (sram_d),
        .sram_gwen     (sram_gwen),
        .sram_wen      (sram_wen),
        .sram_q        (sram_q)
    );

    // Behavioural single-port macro: active-low bit writes, read data one cycle after access
    always @(posedge clk) begin
        if (fill_garbage) begin
            for (int i = 0; i < DEPTH; i++) sram_mem[i] <= DW'($urandom);
        end else if (!sram_cen) begin
            if (!sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q <= sram_mem[sram_a];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_idle    = 1'b0;
        m_pref_wr = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk(tag, 32'({init_done, rd_vld, rd_gnt, wr_gnt, sram_cen, sram_gwen, &sram_wen, |sram_a, |sram_d}),
            32'(9'b0000_111_00));
    endtask

    // One IDLE-phase cycle, entered at posedge+1. Grants and pins are compared with the
    // arbitration rule; the read response is compared with the reference memory next cycle.
    task automatic cycle(input bit rq, input logic [AW-1:0] ra, input bit wq, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [DW-1:0] wb, input bit iq,
                         output bit rg, output bit wg);
        bit            exp_r, exp_w;
        logic [DW-1:0] exp_q;
        rd_req = rq; rd_addr = ra;
        wr_req = wq; wr_addr = wa; wr_data = wd; wr_bwen = wb;
        init_req = iq;
        exp_r = 1'b0;
        exp_w = 1'b0;
        if (m_idle) begin
            if (rq && wq) begin
                if (m_pref_wr) exp_w = 1'b1;
                else           exp_r = 1'b1;
            end else begin
                exp_r = rq;
                exp_w = wq;
            end
        end
        #2;
        chk("rd_gnt", 32'(rd_gnt), 32'(exp_r));
        chk("wr_gnt", 32'(wr_gnt), 32'(exp_w));
        if (exp_w) begin
            chk("wr_a", 32'(sram_a), 32'(wa));
            chk("wr_ctl", 32'({sram_cen, sram_gwen}), 32'd0);
            chk("wr_wen", 32'(sram_wen), 32'(wb));
            chk("wr_d", 32'(sram_d), 32'(wd));
        end else if (exp_r) begin
            chk("rd_a", 32'(sram_a), 32'(ra));
            chk("rd_ctl", 32'({sram_cen, sram_gwen, &sram_wen}), 32'(3'b011));
        end else begin
            chk("idle_ctl", 32'({sram_cen, sram_gwen, &sram_wen}), 32'(3'b111));
            chk("idle_ad", 32'({|sram_a, |sram_d}), 32'd0);
        end
        exp_q = ref_mem[ra];
        if (exp_w) ref_mem[wa] = (ref_mem[wa] & wb) | (wd & ~wb);
        if (m_idle && rq && wq) m_pref_wr = !m_pref_wr;
        if (m_idle && iq) m_idle = 1'b0;
        @(posedge clk);
        #1;
        init_req = 1'b0;
        chk("rd_vld", 32'(rd_vld), 32'(exp_r));
        if (exp_r) chk("rd_data", 32'(rd_data), 32'(exp_q));
        rg = exp_r;
        wg = exp_w;
    endtask

    // Entered at posedge+1 with the controller in INIT_WAIT. stop_at >= 0 asserts reset
    // while that clear address is on the bus and returns with reset held.
    task automatic run_clear(input int stop_at, input bit rq);
        rd_req = rq; rd_addr = 8'h44; wr_req = 1'b0; init_req = 1'b0;
        #2;
        chk("wait_ctl", 32'({sram_cen, rd_gnt, init_done}), 32'(3'b100));
        for (int k = 0; k < DEPTH; k++) begin
            @(posedge clk);
            #1;
            init_req = 1'b0;
            chk("clr_a", 32'(sram_a), 32'(k));
            chk("clr_ctl", 32'({sram_cen, sram_gwen, |sram_wen, |sram_d, init_done, rd_gnt, wr_gnt}), 32'd0);
            if (k == stop_at) begin
                cpurst_b = 1'b0;
                model_reset();
                #1;
                chk_reset_vals("rst_mid_clear");
                return;
            end
            if (k == 10) init_req = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("init_done_rise", 32'(init_done), 32'd1);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        m_idle = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            rg, wg, rp, wp;
        bit [5:0]      order;
        logic [AW-1:0] ra, wa;
        logic [DW-1:0] wd, wb;

        cpurst_b = 1'b0; fill_garbage = 1'b1; init_req = 1'b0;
        rd_req = 1'b1; rd_addr = '0; wr_req = 1'b1; wr_addr = '0; wr_data = '1; wr_bwen = '0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 'x;
        repeat (3) @(posedge clk);
        #1;
        fill_garbage = 1'b0;
        chk_reset_vals("reset_vals");
        rd_req = 1'b0; wr_req = 1'b0;
        @(posedge clk);
        #1;
        cpurst_b = 1'b1;
        run_clear(-1, 1'b0);

        cycle(1, 8'h00, 0, '0, '0, '0, 0, rg, wg);
        chk("rd_zero_00", 32'(rd_data), 32'd0);
        cycle(1, 8'h7F, 0, '0, '0, '0, 0, rg, wg);
        chk("rd_zero_7f", 32'(rd_data), 32'd0);
        cycle(1, 8'hFF, 0, '0, '0, '0, 0, rg, wg);
        chk("rd_zero_ff", 32'(rd_data), 32'd0);

        cycle(0, '0, 1, 8'h12, 23'h55AA3, '0, 0, rg, wg);
        cycle(1, 8'h12, 0, '0, '0, '0, 0, rg, wg);
        chk("wr_rd_full", 32'(rd_data), 32'h55AA3);
        cycle(0, '0, 1, 8'h12, 23'h000FF, 23'h7FFF00, 0, rg, wg);
        cycle(1, 8'h12, 0, '0, '0, '0, 0, rg, wg);
        chk("wr_rd_masked", 32'(rd_data), 32'h55AFF);

        for (int i = 0; i < 6; i++) begin
            cycle(1, 8'h12, 1, AW'(8'h30 + i), DW'($urandom), '0, 0, rg, wg);
            order[5-i] = rg;
        end
        chk("contest_order", 32'(order), 32'(6'b101010));
        cycle(0, '0, 1, 8'h40, 23'h1234, '0, 0, rg, wg);
        cycle(1, 8'h40, 1, 8'h41, 23'h4321, '0, 0, rg, wg);
        chk("rr_after_uncontested", 32'({rg, wg}), 32'(2'b10));

        rp = 1'b0; wp = 1'b0; ra = '0; wa = '0; wd = '0; wb = '0;
        for (int n = 0; n < 400; n++) begin
            if (!rp) begin
                rp = 1'($urandom_range(0, 1));
                ra = AW'($urandom_range(0, 15));
            end
            if (!wp) begin
                wp = 1'($urandom_range(0, 1));
                wa = AW'($urandom_range(0, 15));
                wd = DW'($urandom);
                wb = ($urandom_range(0, 3) == 0) ? DW'($urandom) : '0;
            end
            cycle(rp, ra, wp, wa, wd, wb, 0, rg, wg);
            if (rg) rp = 1'b0;
            if (wg) wp = 1'b0;
        end

        cycle(1, 8'h05, 0, '0, '0, '0, 1, rg, wg);
        chk("init_req_rd_gnt", 32'(rg), 32'd1);
        chk("init_done_drop", 32'(init_done), 32'd0);
        run_clear(-1, 1'b1);
        cycle(1, 8'h05, 0, '0, '0, '0, 0, rg, wg);
        chk("first_gnt_after_clear", 32'(rd_data), 32'd0);

        cycle(1, 8'h03, 0, '0, '0, '0, 0, rg, wg);
        cpurst_b = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_read", 32'(rd_vld), 32'd0);
        chk_reset_vals("rst_mid_read_vals");
        @(posedge clk);
        #1;
        cpurst_b = 1'b1;
        run_clear(100, 1'b0);
        @(posedge clk);
        #1;
        cpurst_b = 1'b1;
        run_clear(-1, 1'b0);
        cycle(1, 8'h12, 0, '0, '0, '0, 0, rg, wg);
        chk("rd_after_reclear", 32'(rd_data), 32'd0);
        cycle(1, 8'h12, 1, 8'h13, 23'h7, '0, 0, rg, wg);
        chk("rr_reset_read_first", 32'({rg, wg}), 32'(2'b10));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ct_spsram_256x23_arb_ctrl.md
# ct_spsram_256x23_arb_ctrl

Access controller for one 256-entry x 23-bit single-port SRAM macro. After reset, and on request, it clears every entry to zero. It then shares the single port between one read requester and one write requester using round-robin arbitration, and returns read data with a registered valid one cycle after grant. It sits between the owning pipeline logic and the SRAM wrapper, and is the only driver of the macro's A/CEN/D/GWEN/WEN pins.

## Interface
- ADDR_WIDTH, 8, SRAM address width (depth = 2^ADDR_WIDTH)
- DATA_WIDTH, 23, SRAM data width
- forever_cpuclk  in  1  clock, shared with the SRAM
- cpurst_b  in  1  reset; asynchronous, active-low
- init_req  in  1  single-cycle pulse requesting a full clear
- init_done  out  1  high when the array is cleared and arbitration is enabled
- rd_req  in  1  read request; held until rd_gnt
- rd_addr  in  ADDR_WIDTH  read address
- rd_gnt  out  1  read accepted this cycle (combinational)
- rd_vld  out  1  rd_data valid (registered)
- rd_data  out  DATA_WIDTH  read data, equals sram_q
- wr_req  in  1  write request; held until wr_gnt
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_bwen  in  DATA_WIDTH  active-low per-bit write mask
- wr_gnt  out  1  write accepted this cycle (combinational)
- sram_a  out  ADDR_WIDTH  SRAM address
- sram_cen  out  1  SRAM chip enable, active-low
- sram_d  out  DATA_WIDTH  SRAM write data
- sram_gwen  out  1  SRAM global write enable, active-low
- sram_wen  out  DATA_WIDTH  SRAM bit write enables, active-low
- sram_q  in  DATA_WIDTH  SRAM read data, valid the cycle after the read access

## Operation
- States:
  - INIT_WAIT: reset state; no SRAM access.
  - INIT: clear walk.
  - IDLE: arbitration.
- INIT_WAIT -> INIT unconditionally on the first clock edge.
- INIT: a clear counter runs 0..2^ADDR_WIDTH-1, one write per cycle.
  - Each write drives sram_a = counter, sram_cen = 0, sram_gwen = 0, sram_wen = all-0, sram_d = 0.
  - At counter = max, the state moves to IDLE and init_done is set at that edge.
- IDLE with init_req = 1: the state moves to INIT_WAIT and init_done clears. Any grant in that cycle is still honoured.
- init_req is ignored in INIT_WAIT and INIT.
- rd_gnt and wr_gnt are 0 outside IDLE. Requesters hold their request.
- Arbitration in IDLE:
  - One requester: it is granted.
  - Both requesters: the side named by rr_ptr is granted.
  - rr_ptr reset value is read-first. It flips to the other side only after a contested grant. Uncontested grants leave it unchanged.
- Granted write: sram_a = wr_addr, sram_cen = 0, sram_gwen = 0, sram_wen = wr_bwen, sram_d = wr_data.
- Granted read: sram_a = rd_addr, sram_cen = 0, sram_gwen = 1, sram_wen = all-1.
- No grant in IDLE: sram_cen = 1, sram_gwen = 1, sram_wen = all-1, sram_a = 0, sram_d = 0.
- rd_vld is set the cycle after rd_gnt and is otherwise 0. rd_data is sram_q unregistered and is meaningful only while rd_vld = 1.
- A write to X followed by a read of X: the read returns the new data. The port serialises the accesses, so no bypass is needed.

## Timing
- Reset values:
  - state INIT_WAIT, clear counter 0, rr_ptr read-first.
  - init_done 0, rd_vld 0.
  - sram_cen 1, sram_gwen 1, sram_wen all-1, sram_a 0, sram_d 0.
  - rd_gnt 0, wr_gnt 0.
- After reset release (default parameters):
  - Edge 1: enter INIT.
  - Cycles 2..257: write addresses 0..255.
  - init_done = 1 from edge 257.
  - First grant possible in the cycle after edge 257.
- Read latency: grant in cycle N, rd_vld = 1 and rd_data valid in cycle N+1. Back-to-back reads give rd_vld high every cycle.
- Throughput: one access per cycle. Under continuous contention, rd and wr alternate.
- Reset asserted mid-INIT or mid-read: everything returns immediately to reset values. rd_vld drops and no response is produced for the lost read. The clear restarts from address 0.
- init_req in the same cycle as a read grant: rd_vld is still produced next cycle. The clear starts one cycle later, from INIT_WAIT.

## Test plan
- Reset release, no requests: 256 consecutive SRAM writes, sram_a 0..255, sram_d = 0, sram_wen = 0. init_done rises at edge 257. Reads of 0x00, 0x7F and 0xFF then return 0.
- Write addr 0x12, data 0x55AA3, wr_bwen 0; next cycle read 0x12: rd_gnt, then rd_vld with rd_data = 0x55AA3.
- Write 0x12 with wr_bwen = 0x7FFF00 over old data 0x55AA3, new data 0x000FF: readback = 0x55AFF.
- rd_req and wr_req held for 6 cycles after init_done: grant order R, W, R, W, R, W. A following uncontested write does not change rr_ptr; the next contest grants R.
- rd_req asserted during INIT: rd_gnt stays 0 until the cycle after init_done. init_req pulse in IDLE: init_done drops and a full 256-write clear repeats.
- cpurst_b asserted at clear address 100: all outputs at reset values. After release, the clear restarts at address 0 and init_done rises 257 cycles later.
